// File: rtl/buffer_cc_filter.sv
// Multi-channel input conditioner: per-channel synchroniser chain into io_mainClk,
// followed by a stability filter and registered rise/fall pulse generation.
module buffer_cc_filter #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      STAGES      = 2,
  parameter int unsigned      FILTER_LEN  = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             io_mainClk,
  input  logic             resetCtrl_systemResetn,
  input  logic             io_sampleTick,
  input  logic [WIDTH-1:0] io_dataIn,
  output logic [WIDTH-1:0] io_syncOut,
  output logic [WIDTH-1:0] io_dataOut,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic             io_anyEdge
);

  localparam int unsigned      CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  (* async_reg = "true" *) logic [WIDTH-1:0] syncStage [STAGES];

  logic [CNT_W-1:0] filterCnt [WIDTH];
  logic [CNT_W-1:0] cntNext   [WIDTH];
  logic [WIDTH-1:0] outNext;
  logic [WIDTH-1:0] riseNext;
  logic [WIDTH-1:0] fallNext;

  // Plain flop chain; nothing may sit between stages or metastability resolution suffers.
  always_ff @(posedge io_mainClk or negedge resetCtrl_systemResetn) begin
    if (!resetCtrl_systemResetn) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        syncStage[k] <= RESET_VALUE;
      end
    end else begin
      syncStage[0] <= io_dataIn;
      for (int k = 1; k < int'(STAGES); k++) begin
        syncStage[k] <= syncStage[k-1];
      end
    end
  end

  assign io_syncOut = syncStage[STAGES-1];

  // A match always clears the count; a mismatch only advances on a qualifying tick.
  always_comb begin
    outNext = io_dataOut;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cntNext[i] = filterCnt[i];
      if (io_syncOut[i] == io_dataOut[i]) begin
        cntNext[i] = '0;
      end else if (io_sampleTick) begin
        if (filterCnt[i] == CNT_LAST) begin
          outNext[i] = io_syncOut[i];
          cntNext[i] = '0;
        end else begin
          cntNext[i] = filterCnt[i] + CNT_ONE;
        end
      end
    end
    riseNext = outNext & ~io_dataOut;
    fallNext = ~outNext & io_dataOut;
  end

  always_ff @(posedge io_mainClk or negedge resetCtrl_systemResetn) begin
    if (!resetCtrl_systemResetn) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        filterCnt[i] <= '0;
      end
      io_dataOut <= RESET_VALUE;
      io_rise    <= '0;
      io_fall    <= '0;
      io_anyEdge <= 1'b0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        filterCnt[i] <= cntNext[i];
      end
      io_dataOut <= outNext;
      io_rise    <= riseNext;
      io_fall    <= fallNext;
      io_anyEdge <= |(riseNext | fallNext);
    end
  end

endmodule

// File: tb/tb_buffer_cc_filter.sv
// Directed bench for buffer_cc_filter: several parameterisations share one clock and reset,
// each exercising a different corner (reset, latency, glitches, tick gating, multi-channel, FILTER_LEN=1).
module tb_buffer_cc_filter;

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  // Reset test instance: WIDTH=4, RESET_VALUE=1010
  logic       tickR = 1'b1;
  logic [3:0] dinR  = 4'b1010;
  logic [3:0] syncR, outR, riseR, fallR;
  logic       anyR;
  buffer_cc_filter #(.WIDTH(4), .STAGES(2), .FILTER_LEN(4), .RESET_VALUE(4'b1010)) dutR (
    .io_mainClk(clk), .resetCtrl_systemResetn(rstN), .io_sampleTick(tickR),
    .io_dataIn(dinR), .io_syncOut(syncR), .io_dataOut(outR),
    .io_rise(riseR), .io_fall(fallR), .io_anyEdge(anyR));

  // Default instance: latency and glitch rejection
  logic tickD = 1'b1;
  logic dinD  = 1'b1;
  logic syncD, outD, riseD, fallD, anyD;
  buffer_cc_filter dutD (
    .io_mainClk(clk), .resetCtrl_systemResetn(rstN), .io_sampleTick(tickD),
    .io_dataIn(dinD), .io_syncOut(syncD), .io_dataOut(outD),
    .io_rise(riseD), .io_fall(fallD), .io_anyEdge(anyD));

  // Tick gating instance: FILTER_LEN=3
  logic tickT = 1'b0;
  logic dinT  = 1'b1;
  logic syncT, outT, riseT, fallT, anyT;
  buffer_cc_filter #(.WIDTH(1), .STAGES(2), .FILTER_LEN(3)) dutT (
    .io_mainClk(clk), .resetCtrl_systemResetn(rstN), .io_sampleTick(tickT),
    .io_dataIn(dinT), .io_syncOut(syncT), .io_dataOut(outT),
    .io_rise(riseT), .io_fall(fallT), .io_anyEdge(anyT));

  // Multi-channel instance: WIDTH=3
  logic       tickM = 1'b1;
  logic [2:0] dinM  = 3'b111;
  logic [2:0] syncM, outM, riseM, fallM;
  logic       anyM;
  buffer_cc_filter #(.WIDTH(3)) dutM (
    .io_mainClk(clk), .resetCtrl_systemResetn(rstN), .io_sampleTick(tickM),
    .io_dataIn(dinM), .io_syncOut(syncM), .io_dataOut(outM),
    .io_rise(riseM), .io_fall(fallM), .io_anyEdge(anyM));

  // Unfiltered instance: FILTER_LEN=1, STAGES=3
  logic tickF = 1'b1;
  logic dinF  = 1'b1;
  logic syncF, outF, riseF, fallF, anyF;
  buffer_cc_filter #(.WIDTH(1), .STAGES(3), .FILTER_LEN(1)) dutF (
    .io_mainClk(clk), .resetCtrl_systemResetn(rstN), .io_sampleTick(tickF),
    .io_dataIn(dinF), .io_syncOut(syncF), .io_dataOut(outF),
    .io_rise(riseF), .io_fall(fallF), .io_anyEdge(anyF));

  typedef struct {
    logic din;
    logic expSync;
    logic expOut;
    logic expRise;
    logic expFall;
  } vecT;

  vecT tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic din);
    dinD = din;
    step();
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    // Latency table for dutD: one row per edge, input 1->0 then back to 1
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    #2 rstN = 1'b0;
    #1;
    checkOutput("por.outR",  8'(outR),  8'h0A);
    checkOutput("por.syncR", 8'(syncR), 8'h0A);
    checkOutput("por.riseR", 8'(riseR), 8'h00);
    checkOutput("por.fallR", 8'(fallR), 8'h00);
    checkOutput("por.anyR",  8'(anyR),  8'h00);
    checkOutput("por.outD",  8'(outD),  8'h01);
    step();
    step();
    #3 rstN = 1'b1;
    repeat (6) step();
    checkOutput("idle.outR", 8'(outR), 8'h0A);
    checkOutput("idle.anyR", 8'(anyR), 8'h00);

    // Reset asserted mid-count, then released with the input still differing
    dinR = 4'b0101;
    repeat (4) step();
    checkOutput("mid.outR", 8'(outR), 8'h0A);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst.outR",  8'(outR),  8'h0A);
    checkOutput("rst.syncR", 8'(syncR), 8'h0A);
    checkOutput("rst.riseR", 8'(riseR), 8'h00);
    checkOutput("rst.fallR", 8'(fallR), 8'h00);
    checkOutput("rst.anyR",  8'(anyR),  8'h00);
    step();
    step();
    checkOutput("rstHold.outR",  8'(outR),  8'h0A);
    checkOutput("rstHold.syncR", 8'(syncR), 8'h0A);
    #3 rstN = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      checkOutput($sformatf("rel%0d.outR", e),  8'(outR),  (e >= 6) ? 8'h05 : 8'h0A);
      checkOutput($sformatf("rel%0d.riseR", e), 8'(riseR), (e == 6) ? 8'h05 : 8'h00);
      checkOutput($sformatf("rel%0d.fallR", e), 8'(fallR), (e == 6) ? 8'h0A : 8'h00);
      checkOutput($sformatf("rel%0d.anyR", e),  8'(anyR),  8'(e == 6));
    end

    // Latency table
    for (int r = 0; r < 14; r++) begin
      applyStimulus(tbl[r].din);
      checkOutput($sformatf("lat%0d.sync", r), 8'(syncD), 8'(tbl[r].expSync));
      checkOutput($sformatf("lat%0d.out", r),  8'(outD),  8'(tbl[r].expOut));
      checkOutput($sformatf("lat%0d.rise", r), 8'(riseD), 8'(tbl[r].expRise));
      checkOutput($sformatf("lat%0d.fall", r), 8'(fallD), 8'(tbl[r].expFall));
    end

    // Short low pulses are rejected
    for (int w = 1; w <= 3; w++) begin
      for (int e = 1; e <= w + 12; e++) begin
        applyStimulus((e <= w) ? 1'b0 : 1'b1);
        checkOutput($sformatf("glitch%0d.%0d.out", w, e),  8'(outD),  8'h01);
        checkOutput($sformatf("glitch%0d.%0d.rise", w, e), 8'(riseD), 8'h00);
        checkOutput($sformatf("glitch%0d.%0d.fall", w, e), 8'(fallD), 8'h00);
      end
    end

    // A 4-cycle low pulse just gets through
    for (int e = 1; e <= 12; e++) begin
      applyStimulus((e <= 4) ? 1'b0 : 1'b1);
      checkOutput($sformatf("pulse4.%0d.out", e),  8'(outD),  8'(!(e >= 6 && e < 10)));
      checkOutput($sformatf("pulse4.%0d.fall", e), 8'(fallD), 8'(e == 6));
      checkOutput($sformatf("pulse4.%0d.rise", e), 8'(riseD), 8'(e == 10));
    end

    // Tick every 4th cycle: fall on the 3rd ticked mismatch (edge 12)
    for (int e = 1; e <= 13; e++) begin
      dinT  = 1'b0;
      tickT = (e % 4 == 0);
      step();
      checkOutput($sformatf("tick.%0d.out", e),  8'(outT),  8'(e < 12));
      checkOutput($sformatf("tick.%0d.fall", e), 8'(fallT), 8'(e == 12));
      checkOutput($sformatf("tick.%0d.rise", e), 8'(riseT), 8'h00);
    end

    // Two ticks counted, match between ticks clears, then 3 fresh ticks needed (edge 28)
    for (int e = 1; e <= 29; e++) begin
      dinT  = (e <= 8) ? 1'b1 : ((e <= 16) ? 1'b0 : 1'b1);
      tickT = (e % 4 == 0);
      step();
      checkOutput($sformatf("tickClr.%0d.out", e),  8'(outT),  8'(e >= 28));
      checkOutput($sformatf("tickClr.%0d.rise", e), 8'(riseT), 8'(e == 28));
      checkOutput($sformatf("tickClr.%0d.fall", e), 8'(fallT), 8'h00);
    end

    // Multi-channel: bit 0 rises while bit 2 falls
    dinM = 3'b110;
    repeat (10) step();
    checkOutput("multi.prep", 8'(outM), 8'h06);
    for (int e = 1; e <= 8; e++) begin
      dinM = 3'b011;
      step();
      checkOutput($sformatf("multi.%0d.out", e),  8'(outM),  (e >= 6) ? 8'h03 : 8'h06);
      checkOutput($sformatf("multi.%0d.rise", e), 8'(riseM), (e == 6) ? 8'h01 : 8'h00);
      checkOutput($sformatf("multi.%0d.fall", e), 8'(fallM), (e == 6) ? 8'h04 : 8'h00);
      checkOutput($sformatf("multi.%0d.any", e),  8'(anyM),  8'(e == 6));
    end

    // FILTER_LEN=1, STAGES=3: single-cycle pulse reproduced 4 edges later
    for (int e = 1; e <= 7; e++) begin
      dinF = (e == 1) ? 1'b0 : 1'b1;
      step();
      checkOutput($sformatf("fl1.%0d.sync", e), 8'(syncF), 8'(e != 3));
      checkOutput($sformatf("fl1.%0d.out", e),  8'(outF),  8'(e != 4));
      checkOutput($sformatf("fl1.%0d.fall", e), 8'(fallF), 8'(e == 4));
      checkOutput($sformatf("fl1.%0d.rise", e), 8'(riseF), 8'(e == 5));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
